// File: rtl/mem_march_bist.sv
// March C- BIST engine driving a DW x 2**AW single-port memory with 1-cycle read latency.
// Runs M0..M5, aborts on the first mismatch and holds that mismatch's address and data.
module mem_march_bist #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_expected,
  output logic [DW-1:0] fail_actual,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_in,
  output logic          write,
  output logic          read,
  input  logic [DW-1:0] data_out
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic          write_q, write_d, read_q, read_d;
  logic          busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [DW-1:0] fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;

  logic          down, last_addr;
  logic [DW-1:0] rd_bg, wr_bg;

  // M3/M4 walk downwards; reads expect the background the previous element wrote.
  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign last_addr = down ? (addr_q == '0) : (addr_q == '1);
  assign rd_bg     = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
  assign wr_bg     = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    data_in_d   = data_in_q;
    write_d     = 1'b0;
    read_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WR;
          elem_d      = 3'd0;
          addr_d      = '0;
          data_in_d   = '0;
          write_d     = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
        end
      end
      S_WR: begin
        if (last_addr) begin
          // Every element after M0 opens with a read; M3/M4 start from the top.
          elem_d  = elem_q + 3'd1;
          addr_d  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
          state_d = S_RD;
          read_d  = 1'b1;
        end else begin
          addr_d = down ? addr_q - AW'(1) : addr_q + AW'(1);
          if (elem_q == 3'd0) begin
            state_d = S_WR;
            write_d = 1'b1;
          end else begin
            state_d = S_RD;
            read_d  = 1'b1;
          end
        end
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        if (data_out != rd_bg) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          fail_d      = 1'b1;
          fail_addr_d = addr_q;
          fail_exp_d  = rd_bg;
          fail_act_d  = data_out;
        end else if (elem_q != 3'd5) begin
          state_d   = S_WR;
          write_d   = 1'b1;
          data_in_d = wr_bg;
        end else if (last_addr) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = S_RD;
          read_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      data_in_q   <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      data_in_q   <= data_in_d;
      write_q     <= write_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_exp_q;
  assign fail_actual   = fail_act_q;
  assign addr          = addr_q;
  assign data_in       = data_in_q;
  assign write         = write_q;
  assign read          = read_q;
endmodule
